// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the counter stream checker.
//   chk_state_e : checker FSM states
//   next_count  : successor of a value in the wrapping 0..max sequence
package counter_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    RESYNC   = 2'd2
  } chk_state_e;

  function automatic int unsigned next_count(input int unsigned x,
                                             input int unsigned max_v);
    return (x == max_v) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/counter_checker_if.sv
// counter_checker_if: valid-strobed counter sample link.
//   in_valid : in_data carries a sample this cycle
//   in_data  : observed count value (WIDTH bits)
//   master   : drives the link (producer)
//   slave    : observes the link (checker)
interface counter_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one event
//   count    : current total
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end

endmodule

// File: rtl/counter_checker.sv
// counter_checker: receive-side monitor for a wrapping 0..MAX_COUNT count
// stream. Locks onto the stream, predicts the next value, flags/counts
// sequence errors and counts matched MAX_COUNT->0 wraps.
//   clk, rst   : clock, asynchronous active-high reset
//   stream     : counter_checker_if.slave (in_valid, in_data)
//   clear      : synchronous clear of state and statistics (beats in_valid)
//   locked     : checker is tracking the stream
//   expected   : predicted next sample, 0 when not locked
//   err_pulse  : one-cycle error strobe
//   err_count  : saturating error total
//   wrap_count : matched wraps, modulo 2**WRAP_CNT_W
// Define COUNTER_CHECKER_SVA_EN to compile embedded assertions and covers.
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned MAX_COUNT  = 128,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ERR_CNT_W  = 16,
  parameter int unsigned WRAP_CNT_W = 16,
  parameter int unsigned RESYNC_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  counter_checker_if.slave      stream,
  input  logic                  clear,
  output logic                  locked,
  output logic [WIDTH-1:0]      expected,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam int unsigned      GOOD_W = $clog2(RESYNC_LEN + 1);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);

  chk_state_e             state, state_d;
  logic [WIDTH-1:0]       exp_q, exp_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [WRAP_CNT_W-1:0]  wrap_q;
  logic                   wrap_inc;
  logic                   err_d;
  logic                   in_range;
  logic                   match;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return WIDTH'(next_count(32'(x), MAX_COUNT));
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCKED;
      exp_q     <= '0;
      good_q    <= '0;
      wrap_q    <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_d;
      exp_q     <= exp_d;
      good_q    <= good_d;
      err_pulse <= err_d;
      if (clear)         wrap_q <= '0;
      else if (wrap_inc) wrap_q <= wrap_q + 1'b1;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    exp_d    = exp_q;
    good_d   = good_q;
    wrap_inc = 1'b0;
    err_d    = 1'b0;
    in_range = (stream.in_data <= MAX_V);
    match    = (stream.in_data == exp_q);

    if (clear) begin
      state_d = UNLOCKED;
      exp_d   = '0;
      good_d  = '0;
    end else if (stream.in_valid) begin
      if (!in_range) begin
        // Out-of-range is never used as a seed, whatever the state.
        err_d   = 1'b1;
        state_d = UNLOCKED;
        good_d  = '0;
      end else begin
        case (state)
          UNLOCKED: begin
            exp_d   = nxt(stream.in_data);
            state_d = LOCKED;
          end
          LOCKED: begin
            if (match) begin
              exp_d    = nxt(exp_q);
              wrap_inc = (stream.in_data == '0);
            end else begin
              err_d   = 1'b1;
              state_d = RESYNC;
              good_d  = '0;
              exp_d   = nxt(stream.in_data);
            end
          end
          RESYNC: begin
            if (match) begin
              exp_d  = nxt(exp_q);
              good_d = good_q + 1'b1;
              if (32'(good_q) + 32'd1 == RESYNC_LEN) state_d = LOCKED;
            end else begin
              // Reseed silently; the error was already reported on lock loss.
              good_d = '0;
              exp_d  = nxt(stream.in_data);
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    locked     = (state == LOCKED);
    expected   = (state == LOCKED) ? exp_q : '0;
    wrap_count = wrap_q;
  end

  sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (err_d),
    .count (err_count)
  );

`ifdef COUNTER_CHECKER_SVA_EN
  a_err_after_valid: assert property (@(posedge clk) disable iff (rst)
    err_pulse |-> $past(stream.in_valid && !clear));

  a_locked_range: assert property (@(posedge clk) disable iff (rst)
    locked |-> (expected <= MAX_V));

  a_err_monotonic: assert property (@(posedge clk) disable iff (rst)
    !$past(clear) |-> (err_count >= $past(err_count)));

  c_lock:   cover property (@(posedge clk) disable iff (rst) $rose(locked));
  c_wrap:   cover property (@(posedge clk) disable iff (rst) wrap_inc && !clear);
  c_error:  cover property (@(posedge clk) disable iff (rst) err_pulse);
  c_relock: cover property (@(posedge clk) disable iff (rst)
    $past(state == RESYNC) && (state == LOCKED));
`else
  // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: table-driven, scoreboarded bench for counter_checker.
module tb_counter_checker;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        clr;
    logic        locked;
    logic [7:0]  expv;
    logic        err;
    logic [15:0] ecnt;
    logic [15:0] wcnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        locked;
  logic [7:0]  expected;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] wrap_count;

  int checks = 0;
  int errors = 0;

  vec_t sb[$];
  vec_t tbl[27];

  counter_checker_if #(.WIDTH(8)) s_if();

  counter_checker #(
    .MAX_COUNT  (128),
    .WIDTH      (8),
    .ERR_CNT_W  (16),
    .WRAP_CNT_W (16),
    .RESYNC_LEN (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stream     (s_if),
    .clear      (clear),
    .locked     (locked),
    .expected   (expected),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic c,
                              input logic l, input logic [7:0] e, input logic er,
                              input logic [15:0] ec, input logic [15:0] wc);
    vec_t r;
    r.valid = v; r.data = d; r.clr = c;
    r.locked = l; r.expv = e; r.err = er; r.ecnt = ec; r.wcnt = wc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    s_if.in_valid = v;
    s_if.in_data  = d;
    clear         = c;
    @(posedge clk);
    #1;
  endtask

  // Expectation is queued when the sample is driven, popped once the
  // registered response is visible.
  task automatic step(input vec_t v, input string name);
    vec_t r;
    sb.push_back(v);
    drive(v.valid, v.data, v.clr);
    r = sb.pop_front();
    chk({name, ".locked"},     32'(locked),     32'(r.locked));
    chk({name, ".expected"},   32'(expected),   32'(r.expv));
    chk({name, ".err_pulse"},  32'(err_pulse),  32'(r.err));
    chk({name, ".err_count"},  32'(err_count),  32'(r.ecnt));
    chk({name, ".wrap_count"}, 32'(wrap_count), 32'(r.wcnt));
  endtask

  initial begin
    // Continues from LOCKED, expected=2, err_count=0, wrap_count=1.
    tbl[0]  = mk(1,   2, 0, 1,   3, 0, 0, 1);
    tbl[1]  = mk(1,   3, 0, 1,   4, 0, 0, 1);
    tbl[2]  = mk(0,  77, 0, 1,   4, 0, 0, 1);  // gap
    tbl[3]  = mk(0, 200, 0, 1,   4, 0, 0, 1);  // gap, bad data ignored
    tbl[4]  = mk(1,   4, 0, 1,   5, 0, 0, 1);
    tbl[5]  = mk(1,   9, 0, 0,   0, 1, 1, 1);  // mismatch -> RESYNC
    tbl[6]  = mk(1,  10, 0, 0,   0, 0, 1, 1);
    tbl[7]  = mk(1,  11, 0, 1,  12, 0, 1, 1);  // relock
    tbl[8]  = mk(1, 200, 0, 0,   0, 1, 2, 1);  // out of range
    tbl[9]  = mk(1,   7, 0, 1,   8, 0, 2, 1);
    tbl[10] = mk(1,   8, 1, 0,   0, 0, 0, 0);  // clear drops sample
    tbl[11] = mk(1,  50, 0, 1,  51, 0, 0, 0);
    tbl[12] = mk(1,  51, 0, 1,  52, 0, 0, 0);
    tbl[13] = mk(1,  90, 0, 0,   0, 1, 1, 0);
    tbl[14] = mk(1,  20, 0, 0,   0, 0, 1, 0);  // RESYNC reseed, no error
    tbl[15] = mk(1,  21, 0, 0,   0, 0, 1, 0);
    tbl[16] = mk(1,  22, 0, 1,  23, 0, 1, 0);
    tbl[17] = mk(1, 127, 0, 0,   0, 1, 2, 0);
    tbl[18] = mk(1, 128, 0, 0,   0, 0, 2, 0);
    tbl[19] = mk(1,   0, 0, 1,   1, 0, 2, 0);  // wrap inside RESYNC not counted
    tbl[20] = mk(1,   1, 0, 1,   2, 0, 2, 0);
    tbl[21] = mk(1,   2, 0, 1,   3, 0, 2, 0);
    tbl[22] = mk(1,   5, 1, 0,   0, 0, 0, 0);
    tbl[23] = mk(1, 128, 0, 1,   0, 0, 0, 0);  // seed at MAX_COUNT
    tbl[24] = mk(1, 129, 0, 0,   0, 1, 1, 0);  // first out-of-range value
    tbl[25] = mk(1, 128, 0, 1,   0, 0, 1, 0);
    tbl[26] = mk(1,   0, 0, 1,   1, 0, 1, 1);

    // Reset state
    rst = 1'b1; clear = 1'b0; s_if.in_valid = 1'b0; s_if.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.locked",     32'(locked),     0);
    chk("reset.expected",   32'(expected),   0);
    chk("reset.err_pulse",  32'(err_pulse),  0);
    chk("reset.err_count",  32'(err_count),  0);
    chk("reset.wrap_count", 32'(wrap_count), 0);
    rst = 1'b0;

    // Full stream with one wrap
    for (int k = 0; k <= 128; k++)
      step(mk(1, 8'(k), 0, 1, (k == 128) ? 8'd0 : 8'(k + 1), 0, 0, 0), "t1_stream");
    step(mk(1, 0, 0, 1, 1, 0, 0, 1), "t1_wrap");
    step(mk(1, 1, 0, 1, 2, 0, 0, 1), "t1_after_wrap");

    for (int i = 0; i < 27; i++)
      step(tbl[i], $sformatf("tbl%0d", i));

    // Saturation of err_count
    step(mk(1, 3, 1, 0, 0, 0, 0, 0), "t5_clear");
    for (int i = 0; i < 65534; i++) drive(1'b1, 8'd200, 1'b0);
    step(mk(1, 200, 0, 0, 0, 1, 16'hFFFF, 0), "t5_sat_reach");
    step(mk(1, 200, 0, 0, 0, 1, 16'hFFFF, 0), "t5_sat_hold");
    step(mk(0, 200, 0, 0, 0, 0, 16'hFFFF, 0), "t5_sat_idle");

    // Asynchronous reset mid-stream
    step(mk(1, 3, 1, 0, 0, 0, 0, 0), "t6_clear");
    for (int k = 0; k < 60; k++) drive(1'b1, 8'(k), 1'b0);
    step(mk(1, 60, 0, 1, 61, 0, 0, 0), "t6_at60");
    s_if.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst.locked",     32'(locked),     0);
    chk("t6_rst.expected",   32'(expected),   0);
    chk("t6_rst.err_pulse",  32'(err_pulse),  0);
    chk("t6_rst.err_count",  32'(err_count),  0);
    chk("t6_rst.wrap_count", 32'(wrap_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(1, 61, 0, 1, 62, 0, 0, 0), "t6_resume61");
    step(mk(1, 62, 0, 1, 63, 0, 0, 0), "t6_resume62");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
